// File: rtl/clap_pkg.sv
// Shared types and helpers for the clap event detector.
package clap_pkg;
  localparam int DEF_ENERGY_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_QUIET = 2'd3
  } clap_state_e;

  // Bits needed to hold 0..val-1; never less than 1.
  function automatic int clogb2(input int val);
    int w;
    w = 1;
    while ((1 << w) < val) w++;
    return w;
  endfunction
endpackage

// File: rtl/clap_bg_estimator.sv
// Exponential moving average of the energy stream; bg_level is the integer part.
module clap_bg_estimator
  import clap_pkg::*;
#(
  parameter int          ENERGY_WIDTH = DEF_ENERGY_WIDTH,
  parameter int          ALPHA_SHIFT  = 6,
  parameter int unsigned BG_INIT      = 0
) (
  input  logic                    clock,
  input  logic                    energy_nreset,
  input  logic                    update_en,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  output logic [ENERGY_WIDTH-1:0] bg_level
);
  localparam int ACC_W = ENERGY_WIDTH + ALPHA_SHIFT;

  logic [ACC_W-1:0] bg_acc_q, bg_acc_d;

  // acc - acc/2^A + e stays below 2^ACC_W since acc/2^A never exceeds the max sample.
  always_comb begin
    bg_acc_d = bg_acc_q;
    if (update_en)
      bg_acc_d = bg_acc_q - (bg_acc_q >> ALPHA_SHIFT) + ACC_W'(energy_data);
  end

  always_ff @(posedge clock or negedge energy_nreset) begin
    if (!energy_nreset) bg_acc_q <= ACC_W'(BG_INIT) << ALPHA_SHIFT;
    else                bg_acc_q <= bg_acc_d;
  end

  assign bg_level = bg_acc_q[ACC_W-1:ALPHA_SHIFT];
endmodule

// File: rtl/clap_event_detector.sv
// Clap detector: energy spike over adaptive background -> one clap token, then holdoff and re-arm.
module clap_event_detector
  import clap_pkg::*;
#(
  parameter int          ENERGY_WIDTH = DEF_ENERGY_WIDTH,
  parameter int          ALPHA_SHIFT  = 6,
  parameter int          GAIN_SHIFT   = 2,
  parameter int unsigned ABS_MIN      = 1024,
  parameter int          N_D          = 16,
  parameter int unsigned BG_INIT      = 0
) (
  input  logic                    clock,
  input  logic                    energy_nreset,
  input  logic [ENERGY_WIDTH-1:0] energy_data,
  input  logic                    energy_valid,
  output logic                    energy_ready,
  output logic                    clap_valid,
  input  logic                    clap_ready,
  output logic [ENERGY_WIDTH-1:0] bg_level
);
  localparam int CNT_W = clogb2(N_D);
  localparam int CMP_W = ENERGY_WIDTH + GAIN_SHIFT;

  clap_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             energy_ready_q, energy_ready_d;
  logic             clap_valid_q, clap_valid_d;
  logic             accept, gain_hi, trig, bg_update;

  clap_bg_estimator #(
    .ENERGY_WIDTH(ENERGY_WIDTH),
    .ALPHA_SHIFT (ALPHA_SHIFT),
    .BG_INIT     (BG_INIT)
  ) u_bg (
    .clock        (clock),
    .energy_nreset(energy_nreset),
    .update_en    (bg_update),
    .energy_data  (energy_data),
    .bg_level     (bg_level)
  );

  assign accept  = energy_valid && energy_ready_q;
  // Widened compare so the shifted background never wraps.
  assign gain_hi = CMP_W'(energy_data) > (CMP_W'(bg_level) << GAIN_SHIFT);
  assign trig    = (energy_data > ENERGY_WIDTH'(ABS_MIN)) && gain_hi;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bg_update = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (trig) state_d   = ST_PEND;
          else      bg_update = 1'b1;
        end
      end
      ST_PEND: begin
        if (clap_valid_q && clap_ready) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (accept) begin
          if (cnt_q == CNT_W'(N_D - 1)) begin
            state_d = ST_QUIET;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_QUIET: begin
        // Re-arm only after energy dips below the gain threshold.
        if (accept) begin
          bg_update = 1'b1;
          if (!gain_hi) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    energy_ready_d = (state_d != ST_PEND);
    clap_valid_d   = (state_d == ST_PEND);
  end

  always_ff @(posedge clock or negedge energy_nreset) begin
    if (!energy_nreset) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      energy_ready_q <= 1'b0;
      clap_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      energy_ready_q <= energy_ready_d;
      clap_valid_q   <= clap_valid_d;
    end
  end

  assign energy_ready = energy_ready_q;
  assign clap_valid   = clap_valid_q;
endmodule

// File: tb/tb_clap_event_detector.sv
// Scoreboard bench for clap_event_detector: per-cycle reference model plus scenario checks.
module tb_clap_event_detector;
  localparam int EW = 32;
  localparam int M_IDLE = 0, M_PEND = 1, M_HOLD = 2, M_QUIET = 3;

  logic          clock = 1'b0;
  logic          energy_nreset = 1'b0;
  logic          energy_valid = 1'b0;
  logic          clap_ready = 1'b0;
  logic [EW-1:0] energy_data = '0;
  logic          energy_ready, clap_valid;
  logic [EW-1:0] bg_level;

  clap_event_detector dut (
    .clock        (clock),
    .energy_nreset(energy_nreset),
    .energy_data  (energy_data),
    .energy_valid (energy_valid),
    .energy_ready (energy_ready),
    .clap_valid   (clap_valid),
    .clap_ready   (clap_ready),
    .bg_level     (bg_level)
  );

  always #5 clock = ~clock;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    longint bg;
    bit     cv;
    bit     rdy;
  } exp_t;

  exp_t   exp_q[$];
  int     m_state, m_cnt;
  longint m_acc;
  bit     m_rdy, m_cv, acc_prev;
  int     m_tok = 0, d_tok = 0;
  bit     rec_en = 0, run_id = 0;
  longint bg_hist0[$], bg_hist1[$];

  // Inputs are stable at the falling edge: check last edge's outputs, then
  // advance the model with what the DUT will see at the next rising edge.
  always @(negedge clock) begin : mon
    bit     acc, gh, tr;
    longint e, bgl;
    exp_t   x;
    if (!energy_nreset) begin
      m_state  = M_IDLE;
      m_acc    = 0;
      m_cnt    = 0;
      m_rdy    = 0;
      m_cv     = 0;
      acc_prev = 0;
      exp_q.delete();
    end else begin
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("bg_level", bg_level, x.bg);
        chk("clap_valid", clap_valid, x.cv);
        chk("energy_ready", energy_ready, x.rdy);
      end
      if (acc_prev && rec_en) begin
        if (run_id) bg_hist1.push_back(bg_level);
        else        bg_hist0.push_back(bg_level);
      end
      if (clap_valid && clap_ready) d_tok++;
      if (m_cv && clap_ready) m_tok++;
      acc = energy_valid && m_rdy;
      e   = energy_data;
      bgl = m_acc / 64;
      gh  = e > bgl * 4;
      tr  = gh && (e > 1024);
      case (m_state)
        M_IDLE:  if (acc) begin
                   if (tr) m_state = M_PEND;
                   else    m_acc = m_acc - m_acc / 64 + e;
                 end
        M_PEND:  if (m_cv && clap_ready) begin m_state = M_HOLD; m_cnt = 0; end
        M_HOLD:  if (acc) begin
                   if (m_cnt == 15) begin m_state = M_QUIET; m_cnt = 0; end
                   else m_cnt++;
                 end
        default: if (acc) begin
                   m_acc = m_acc - m_acc / 64 + e;
                   if (!gh) m_state = M_IDLE;
                 end
      endcase
      m_rdy = (m_state != M_PEND);
      m_cv  = (m_state == M_PEND);
      x.bg  = m_acc / 64;
      x.cv  = m_cv;
      x.rdy = m_rdy;
      exp_q.push_back(x);
      acc_prev = acc;
    end
  end

  // All drivers change inputs 2 time units after the rising edge.
  task automatic step(input int n);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic send(input logic [EW-1:0] e, input bit gap);
    energy_valid = 1'b1;
    energy_data  = e;
    step(1);
    energy_valid = 1'b0;
    if (gap) step(1);
  endtask

  task automatic do_reset();
    energy_valid  = 1'b0;
    clap_ready    = 1'b0;
    energy_nreset = 1'b0;
    step(1);
    energy_nreset = 1'b1;
    step(1);
  endtask

  task automatic run_seq(input bit gap);
    int t0;
    t0 = d_tok;
    do_reset();
    repeat (400) send(1000, gap);
    send(5000, gap);
    chk("s3_clap_after_spike", clap_valid, 1);
    // A sample offered while the token is pending must be refused.
    energy_valid = 1'b1;
    energy_data  = 1000;
    repeat (5) begin
      step(1);
      chk("s3_held_clap_valid", clap_valid, 1);
      chk("s3_held_ready_low", energy_ready, 0);
    end
    energy_valid = 1'b0;
    clap_ready   = 1'b1;
    step(1);
    clap_ready = 1'b0;
    chk("s3_clap_drop", clap_valid, 0);
    chk("s3_ready_back", energy_ready, 1);
    chk("s3_tokens", d_tok - t0, 1);
    repeat (8) send(1000, gap);
    send(5000, gap);
    repeat (7) send(1000, gap);
    chk("s4_holdoff_no_clap", d_tok - t0, 1);
    chk("s4_clap_low", clap_valid, 0);
    send(5000, gap);
    send(5000, gap);
    chk("s5_quiet_no_clap", clap_valid, 0);
    send(1000, gap);
    send(5000, gap);
    chk("s5_rearm_clap", clap_valid, 1);
    clap_ready = 1'b1;
    step(1);
    clap_ready = 1'b0;
    chk("s5_tokens", d_tok - t0, 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // 1: reset values and ready one edge after release
    step(2);
    chk("rst_clap_valid", clap_valid, 0);
    chk("rst_ready", energy_ready, 0);
    chk("rst_bg", bg_level, 0);
    energy_nreset = 1'b1;
    @(posedge clock); #1;
    chk("rst_ready_one_edge", energy_ready, 1);
    #1;

    // 2: quiet background below the absolute floor
    repeat (400) send(500, 0);
    chk("s2_bg_settled", bg_level >= 490, 1);
    chk("s2_no_clap", d_tok, 0);

    // 3-5 contiguous, then 6 with gaps; bg per sample index must match
    rec_en = 1;
    run_id = 0;
    run_seq(0);
    run_id = 1;
    run_seq(1);
    rec_en = 0;
    chk("s6_samples_contig", bg_hist0.size(), 421);
    chk("s6_samples_gapped", bg_hist1.size(), bg_hist0.size());
    for (int i = 0; i < bg_hist0.size() && i < bg_hist1.size(); i++)
      chk("s6_bg_at_index", bg_hist1[i], bg_hist0[i]);

    // Floor boundary, then asynchronous reset while a token is pending
    do_reset();
    send(1024, 0);
    chk("abs_min_equal_no_clap", clap_valid, 0);
    send(1025, 0);
    chk("abs_min_plus1_clap", clap_valid, 1);
    #1;
    energy_nreset = 1'b0;
    #1;
    chk("rst_pend_clap_valid", clap_valid, 0);
    chk("rst_pend_ready", energy_ready, 0);
    chk("rst_pend_bg", bg_level, 0);
    @(posedge clock); #2;
    energy_nreset = 1'b1;
    @(posedge clock); #1;
    chk("rst_pend_ready_one_edge", energy_ready, 1);
    chk("rst_pend_no_token", clap_valid, 0);
    #1;
    step(2);
    chk("token_total_model", d_tok, m_tok);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/clap_event_detector.md
Name: clap_event_detector

Overview:
- Transmitter side of the clap/energy handshake pair. Consumes the per-window energy sample stream and emits one clap_valid/clap_ready token per detected clap.
- The successive-claps counter downstream sees the same energy handshake (energy_valid and energy_ready) and this block's clap token.
- Detection rule: sample exceeds an adaptive background (exponential moving average) by a fixed gain and an absolute floor. Followed by a holdoff of N_D samples, then a re-arm condition (energy must drop back below trigger).

Parameters:
- ENERGY_WIDTH, 32, width of energy_data (unsigned).
- ALPHA_SHIFT, 6, EMA time constant: bg += (e - bg) / 2^ALPHA_SHIFT.
- GAIN_SHIFT, 2, trigger when e > bg * 2^GAIN_SHIFT.
- ABS_MIN, 1024, trigger also requires e > ABS_MIN.
- N_D, 16, holdoff length in accepted samples after a clap handshake (N_D >= 1).
- BG_INIT, 0, background level loaded at reset.

Ports:
- clock  in  1  sampling clock.
- energy_nreset  in  1  reset, asynchronous, active-low.
- energy_data  in  ENERGY_WIDTH  energy sample.
- energy_valid  in  1  sample valid.
- energy_ready  out  1  sample accepted when energy_valid && energy_ready.
- clap_valid  out  1  clap token valid.
- clap_ready  in  1  downstream accepts token.
- bg_level  out  ENERGY_WIDTH  current background integer part (debug/threshold tap).

Behaviour:
Reset (energy_nreset=0, asynchronous):
- state=IDLE, clap_valid=0, energy_ready=0, holdoff count=0.
- bg_acc=BG_INIT<<ALPHA_SHIFT, so bg_level=BG_INIT.
- Reset mid-PEND drops clap_valid with no handshake; this is required.

Registers and arithmetic:
- energy_ready is registered. It goes 1 on the first clock edge after reset release. It is 0 only while state=PEND.
- bg_acc width is ENERGY_WIDTH+ALPHA_SHIFT, unsigned. bg_level = bg_acc >> ALPHA_SHIFT.
- Update on an accepted sample, when enabled: bg_acc <= bg_acc - (bg_acc >> ALPHA_SHIFT) + e. This never overflows.
- trig = (e > ABS_MIN) && ({e} > {bg_level, GAIN_SHIFT'b0}). The compare is done in ENERGY_WIDTH+GAIN_SHIFT bits with no truncation. trig always uses bg_level before this sample's update.

States:
- IDLE
  - Accepted sample, trig=1: go to PEND. clap_valid=1 on the same edge (1-cycle latency, sample to token). bg not updated.
  - Accepted sample, trig=0: update bg; stay in IDLE.
- PEND
  - clap_valid=1 and energy_ready=0; clap_valid is held until clap_ready=1.
  - On clap_valid && clap_ready: go to HOLD, clap_valid=0 on the next edge, count=0.
  - Exactly one token per clap.
- HOLD
  - bg frozen. Each accepted sample increments count (width clogb2(N_D)).
  - On the accepted sample with count==N_D-1: go to QUIET.
  - trig is ignored while in HOLD.
- QUIET
  - Accepted sample: update bg.
  - If the sample is not above the gain threshold (ignore ABS_MIN): go to IDLE. Otherwise stay.
  - No clap can issue from QUIET; a dip is required to re-arm.

Edge cases:
- energy_valid=0 cycles: nothing changes except the handshakes.
- Gaps in energy_valid do not advance the holdoff.
- The downstream counter resets on its own window; this block ignores that.

Decomposition:
- Shared package clap_pkg:
  - state encoding (IDLE, PEND, HOLD, QUIET, 2 bits);
  - clogb2 function;
  - default ENERGY_WIDTH.
- One sub-module, clap_bg_estimator:
  - contains the EMA accumulator and bg_level;
  - ports clock, energy_nreset, update_en, energy_data, bg_level.
- The FSM, trig compare and handshakes stay in the top.

Test Plan:
1. Reset: drive energy_nreset=0 mid-PEND.
   - clap_valid=0, energy_ready=0, bg_level=BG_INIT=0 immediately, without a clock.
   - After release, energy_ready=1 after 1 edge.
2. 400 accepted samples of 500.
   - bg_level >= 490; no clap, since below ABS_MIN.
3. Settle bg_level to ~1000 with samples of 1000, then send one 5000 while holding clap_ready=0 for 5 cycles.
   - clap_valid=1 the cycle after the sample, held, with energy_ready=0 throughout.
   - Raise clap_ready: exactly one handshake, then clap_valid=0 and energy_ready=1.
4. After the handshake, send 8 samples of 1000, then 5000, then 7 samples of 1000.
   - The spike falls inside the holdoff: no clap. Count reaches N_D=16, and the state goes QUIET then IDLE on the next 1000 sample.
5. Re-arm check: after holdoff, send 2 samples of 5000, then 1000, then 5000.
   - No clap on the first two (QUIET). The 1000 returns the state to IDLE. The final 5000 triggers a clap (bg ~1100, so threshold ~4400).
6. Repeat scenario 3 with energy_valid toggling every other cycle.
   - Same token count and the same holdoff length in samples, not cycles.
   - bg_level is identical to the contiguous run at the same sample index.
